// File: rtl/mesh_router_xy_pkg.sv
// Shared definitions for the XY mesh router: port indices, port enum and
// helpers that pull the destination coordinates out of a flit header.
package mesh_pkg;

  localparam int NUM_PORTS = 5;
  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;

  // Widest flit the header helpers accept; flits are zero-extended to this.
  localparam int FLIT_MAX_W = 256;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_S = 3'd3,
    PORT_W = 3'd4
  } port_e;

  // Destination X sits in the top x_w bits of the flit.
  function automatic logic [31:0] get_dst_x(input logic [FLIT_MAX_W-1:0] flit,
                                            input int data_w, input int x_w);
    logic [FLIT_MAX_W-1:0] shifted;
    shifted = flit >> (data_w - x_w);
    return 32'(shifted & ((FLIT_MAX_W'(1) << x_w) - FLIT_MAX_W'(1)));
  endfunction

  // Destination Y sits directly below the X field.
  function automatic logic [31:0] get_dst_y(input logic [FLIT_MAX_W-1:0] flit,
                                            input int data_w, input int x_w,
                                            input int y_w);
    logic [FLIT_MAX_W-1:0] shifted;
    shifted = flit >> (data_w - x_w - y_w);
    return 32'(shifted & ((FLIT_MAX_W'(1) << y_w) - FLIT_MAX_W'(1)));
  endfunction

endpackage

// File: rtl/mesh_router_xy_if.sv
// Flit handshake bundle for the five router ports. The router sits on the
// slave side; the neighbours (or a bench) drive the master side.
interface mesh_router_xy_if #(
  parameter int DATA_WIDTH = 32
);
  logic [5*DATA_WIDTH-1:0] data_in;
  logic [4:0]              valid_in;
  logic [4:0]              full_out;
  logic [5*DATA_WIDTH-1:0] data_out;
  logic [4:0]              valid_out;
  logic [4:0]              full_in;

  modport slave (
    input  data_in, valid_in, full_in,
    output full_out, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, full_in,
    input  full_out, data_out, valid_out
  );
endinterface

// File: rtl/mesh_router_xy_fifo.sv
// router_fifo: small synchronous FIFO used as the input buffer of each port.
// Head data is shown combinationally; writes are ignored when full and reads
// when empty, so the count can never over- or underflow.
module router_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end

  // Storage array needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mesh_router_xy.sv
// mesh_router_xy: 5-port (L/N/E/S/W) XY-routed mesh node with input FIFOs,
// per-output round-robin arbitration and registered outputs. Ports with no
// neighbour are disabled through EDGE_MASK; flits heading there are dropped
// and counted. Optional per-output sent-flit counters are built only when the
// macro MESH_ROUTER_STATS_EN is defined; otherwise flit_cnt reads zero.
module mesh_router_xy
  import mesh_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          X_W        = 2,
  parameter int          Y_W        = 1,
  parameter int          MY_X       = 0,
  parameter int          MY_Y       = 0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [4:0]  EDGE_MASK  = 5'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mesh_router_xy_if.slave            bus,
  output logic [7:0]                 drop_cnt,
  output logic [NUM_PORTS*16-1:0]    flit_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fifo_head  [NUM_PORTS];
  logic [CW-1:0]         fifo_count [NUM_PORTS];
  logic [NUM_PORTS-1:0]  fifo_wr, fifo_pop, fifo_full, fifo_empty;

  logic [31:0]           hd_x  [NUM_PORTS];
  logic [31:0]           hd_y  [NUM_PORTS];
  logic [2:0]            route [NUM_PORTS];
  logic [NUM_PORTS-1:0]  req   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  drop_req;

  logic [NUM_PORTS-1:0]  gnt_vld, out_free;
  logic [2:0]            gnt_idx [NUM_PORTS];
  logic [2:0]            rr_q    [NUM_PORTS];
  logic [2:0]            rr_d    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] dout_q  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] dout_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  vout_q, vout_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [8:0]            drop_sum;

  // Input buffers; masked ports are never written and always report full.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    router_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr[p]),
      .wr_data (bus.data_in[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (fifo_pop[p]),
      .rd_data (fifo_head[p]),
      .full    (fifo_full[p]),
      .empty   (fifo_empty[p]),
      .count   (fifo_count[p])
    );
    assign fifo_wr[p]      = bus.valid_in[p] & ~fifo_full[p] & ~EDGE_MASK[p];
    assign bus.full_out[p] = EDGE_MASK[p] | (fifo_count[p] == CW'(FIFO_DEPTH));
    assign bus.data_out[p*DATA_WIDTH +: DATA_WIDTH] = dout_q[p];
  end

  assign bus.valid_out = vout_q;
  assign drop_cnt      = drop_cnt_q;

  // XY route of each FIFO head: resolve X first, then Y, else deliver locally.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      hd_x[p] = get_dst_x(FLIT_MAX_W'(fifo_head[p]), DATA_WIDTH, X_W);
      hd_y[p] = get_dst_y(FLIT_MAX_W'(fifo_head[p]), DATA_WIDTH, X_W, Y_W);
      if (hd_x[p] > 32'(MY_X))      route[p] = 3'(P_E);
      else if (hd_x[p] < 32'(MY_X)) route[p] = 3'(P_W);
      else if (hd_y[p] > 32'(MY_Y)) route[p] = 3'(P_S);
      else if (hd_y[p] < 32'(MY_Y)) route[p] = 3'(P_N);
      else                          route[p] = 3'(P_L);
    end
  end

  // Requests per output (req[o][p]) and drop requests for heads aimed at masked ports.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        req[o][p] = ~fifo_empty[p] & (route[p] == 3'(o)) & ~EDGE_MASK[o];
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      drop_req[p] = ~fifo_empty[p] & EDGE_MASK[route[p]];
    end
  end

  // Round-robin arbitration and output register next-state; a grant only
  // takes effect when the output register can accept a new flit.
  always_comb begin : arb_comb
    int cand;
    cand     = 0;
    fifo_pop = drop_req;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_vld[o]  = 1'b0;
      gnt_idx[o]  = 3'd0;
      out_free[o] = ~vout_q[o] | ~bus.full_in[o];
      rr_d[o]     = rr_q[o];
      dout_d[o]   = dout_q[o];
      vout_d[o]   = vout_q[o];
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = (int'(rr_q[o]) + k) % NUM_PORTS;
        if (!gnt_vld[o] && req[o][cand]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = 3'(cand);
        end
      end
      if (out_free[o]) begin
        if (gnt_vld[o]) begin
          dout_d[o]            = fifo_head[gnt_idx[o]];
          vout_d[o]            = 1'b1;
          rr_d[o]              = (gnt_idx[o] == 3'(NUM_PORTS-1)) ? 3'd0 : gnt_idx[o] + 3'd1;
          fifo_pop[gnt_idx[o]] = 1'b1;
        end else begin
          vout_d[o] = 1'b0;
        end
      end
    end
  end

  // Saturating drop counter; several inputs may drop in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int p = 0; p < NUM_PORTS; p++) begin
      drop_sum = drop_sum + {8'd0, drop_req[p]};
    end
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Output registers, round-robin pointers and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        rr_q[o]   <= 3'd0;
        dout_q[o] <= '0;
      end
      vout_q     <= '0;
      drop_cnt_q <= 8'd0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        rr_q[o]   <= rr_d[o];
        dout_q[o] <= dout_d[o];
      end
      vout_q     <= vout_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef MESH_ROUTER_STATS_EN
  logic [15:0] flit_cnt_q [NUM_PORTS];
  logic [15:0] flit_cnt_d [NUM_PORTS];

  // A flit leaves output o whenever it is valid and downstream is not full.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      flit_cnt_d[o] = flit_cnt_q[o] + {15'd0, vout_q[o] & ~bus.full_in[o]};
    end
  end

  // Per-output sent-flit counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) flit_cnt_q[o] <= 16'd0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) flit_cnt_q[o] <= flit_cnt_d[o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_stat
    assign flit_cnt[o*16 +: 16] = flit_cnt_q[o];
  end
`else
  assign flit_cnt = '0;
`endif

endmodule
